// File: rtl/jcs_clock_stepper_pkg.sv
// Shared definitions for the jcscpu clock stepper: quarter encodings, step
// constants and the quarter-to-strobe truth table.
package jcs_clock_stepper_pkg;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} qtr_e;

  localparam logic [5:0] STEP_RST   = 6'b000000;
  localparam logic [5:0] STEP_FIRST = 6'b000001;

  typedef struct packed {
    logic clk;
    logic clk_e;
    logic clk_s;
  } strobe_t;

  localparam strobe_t STB_Q0 = 3'b110;
  localparam strobe_t STB_Q1 = 3'b111;
  localparam strobe_t STB_Q2 = 3'b010;
  localparam strobe_t STB_Q3 = 3'b000;

  function automatic strobe_t phase_strobes(qtr_e q);
    case (q)
      Q0:      phase_strobes = STB_Q0;
      Q1:      phase_strobes = STB_Q1;
      Q2:      phase_strobes = STB_Q2;
      default: phase_strobes = STB_Q3;
    endcase
  endfunction

endpackage

// File: rtl/jcs_clock_stepper_phase_decode.sv
// Combinational quarter-to-strobe map; clk_e = clk|clk_d, clk_s = clk&clk_d.
module jcs_phase_decode
  import jcs_clock_stepper_pkg::*;
(
  input  logic [1:0] q_i,
  output logic       clk_o,
  output logic       clk_e_o,
  output logic       clk_s_o
);

  strobe_t stb;

  always_comb begin
    stb     = phase_strobes(qtr_e'(q_i));
    clk_o   = stb.clk;
    clk_e_o = stb.clk_e;
    clk_s_o = stb.clk_s;
  end

endmodule

// File: rtl/jcs_clock_stepper.sv
// Quarter-phase generator and six-step ring for the jcscpu datapath.
// Free-runs at DIV clocks per quarter or advances one quarter per STEPQ.
module jcs_clock_stepper
  import jcs_clock_stepper_pkg::*;
#(
  parameter int unsigned DIV = 12_500_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        STEPQ,
  output logic        CLKO,
  output logic        CLKE,
  output logic        CLKS,
  output logic [5:0]  STEP,
  output logic [1:0]  QTR,
  output logic [15:0] CYC
);

  localparam logic [23:0] DIV_M1 = 24'(DIV - 1);

  logic [23:0] div_cnt_q, div_cnt_d;
  qtr_e        q_q, q_d;
  logic [5:0]  step_q, step_d;
  logic [15:0] cyc_q, cyc_d;
  logic        adv;
  logic        clko_d, clke_d, clks_d;
  logic        clko_q, clke_q, clks_q;

  always_comb begin
    adv       = RUN ? (div_cnt_q == DIV_M1) : STEPQ;
    div_cnt_d = (RUN && !adv) ? div_cnt_q + 24'd1 : 24'd0;
    q_d       = adv ? qtr_e'(q_q + 2'd1) : q_q;
    step_d    = step_q;
    cyc_d     = cyc_q;
    // The ring only moves when a new clk cycle begins (Q3 -> Q0).
    if (adv && q_q == Q3) begin
      if (step_q == STEP_RST) begin
        step_d = STEP_FIRST;
      end else if (step_q[5]) begin
        step_d = STEP_FIRST;
        cyc_d  = cyc_q + 16'd1;
      end else begin
        step_d = {step_q[4:0], 1'b0};
      end
    end
  end

  // Strobes are decoded from next-state q so they register on the same edge.
  jcs_phase_decode u_dec (
    .q_i     (q_d),
    .clk_o   (clko_d),
    .clk_e_o (clke_d),
    .clk_s_o (clks_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= 24'd0;
      q_q       <= Q3;
      step_q    <= STEP_RST;
      cyc_q     <= 16'd0;
      clko_q    <= 1'b0;
      clke_q    <= 1'b0;
      clks_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      q_q       <= q_d;
      step_q    <= step_d;
      cyc_q     <= cyc_d;
      clko_q    <= clko_d;
      clke_q    <= clke_d;
      clks_q    <= clks_d;
    end
  end

  assign CLKO = clko_q;
  assign CLKE = clke_q;
  assign CLKS = clks_q;
  assign STEP = step_q;
  assign QTR  = q_q;
  assign CYC  = cyc_q;

endmodule

// File: tb/tb_jcs_clock_stepper.sv
// Directed bench for jcs_clock_stepper: manual vector table plus run-mode,
// priority, mid-cycle reset and CYC wrap sequences.
module tb_jcs_clock_stepper;

  logic        CLK = 1'b0;
  logic        RST, RUN, STEPQ, RUN1;
  logic        CLKO, CLKE, CLKS, CLKO1, CLKE1, CLKS1;
  logic [5:0]  STEP, STEP1;
  logic [1:0]  QTR, QTR1;
  logic [15:0] CYC, CYC1;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  jcs_clock_stepper #(.DIV(4)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEPQ(STEPQ),
    .CLKO(CLKO), .CLKE(CLKE), .CLKS(CLKS),
    .STEP(STEP), .QTR(QTR), .CYC(CYC)
  );

  jcs_clock_stepper #(.DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .RUN(RUN1), .STEPQ(1'b0),
    .CLKO(CLKO1), .CLKE(CLKE1), .CLKS(CLKS1),
    .STEP(STEP1), .QTR(QTR1), .CYC(CYC1)
  );

  typedef struct {
    logic        stepq;
    logic [1:0]  qtr;
    logic [2:0]  stb;
    logic [5:0]  step;
    logic [15:0] cyc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] stb_of(input logic [1:0] q);
    case (q)
      2'd0:    return 3'b110;
      2'd1:    return 3'b111;
      2'd2:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk_all(input string nm, input logic [1:0] q, input logic [5:0] st,
                         input logic [15:0] cy);
    chk({nm, ".qtr"}, 32'(QTR), 32'(q));
    chk({nm, ".stb"}, 32'({CLKO, CLKE, CLKS}), 32'(stb_of(q)));
    chk({nm, ".step"}, 32'(STEP), 32'(st));
    chk({nm, ".cyc"}, 32'(CYC), 32'(cy));
  endtask

  task automatic do_reset();
    RST = 1'b1; RUN = 1'b0; STEPQ = 1'b0; RUN1 = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic pulse();
    STEPQ = 1'b1; tick(); STEPQ = 1'b0;
  endtask

  vec_t vecs[6];
  int   nadv, e;
  logic [5:0]  es;
  logic [15:0] ec;
  logic [1:0]  eq;

  initial begin
    vecs[0] = '{1'b1, 2'd0, 3'b110, 6'b000001, 16'd0};
    vecs[1] = '{1'b1, 2'd1, 3'b111, 6'b000001, 16'd0};
    vecs[2] = '{1'b0, 2'd1, 3'b111, 6'b000001, 16'd0};
    vecs[3] = '{1'b1, 2'd2, 3'b010, 6'b000001, 16'd0};
    vecs[4] = '{1'b1, 2'd3, 3'b000, 6'b000001, 16'd0};
    vecs[5] = '{1'b1, 2'd0, 3'b110, 6'b000010, 16'd0};

    // Reset then idle
    do_reset();
    chk_all("rst", 2'd3, 6'd0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", 2'd3, 6'd0, 16'd0);
    end

    // Manual stepping table, including back-to-back pulses
    for (int i = 0; i < 6; i++) begin
      STEPQ = vecs[i].stepq;
      tick();
      chk($sformatf("vec%0d.qtr", i), 32'(QTR), 32'(vecs[i].qtr));
      chk($sformatf("vec%0d.stb", i), 32'({CLKO, CLKE, CLKS}), 32'(vecs[i].stb));
      chk($sformatf("vec%0d.step", i), 32'(STEP), 32'(vecs[i].step));
      chk($sformatf("vec%0d.cyc", i), 32'(CYC), 32'(vecs[i].cyc));
    end
    STEPQ = 1'b0;

    // Full instruction at DIV=4 with STEPQ noise that must be ignored
    do_reset();
    RUN = 1'b1;
    for (int k = 1; k <= 106; k++) begin
      STEPQ = 1'($urandom);
      tick();
      nadv = k / 4;
      e    = (nadv == 0) ? 0 : (nadv - 1) / 4 + 1;
      eq   = 2'((3 + nadv) % 4);
      es   = (e == 0) ? 6'd0 : 6'(1 << ((e - 1) % 6));
      ec   = (e == 0) ? 16'd0 : 16'((e - 1) / 6);
      chk_all($sformatf("run%0d", k), eq, es, ec);
    end

    // RUN drops mid-quarter: frozen, then one STEPQ advances one quarter
    RUN = 1'b0; STEPQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("frz", 2'd1, 6'b000001, 16'd1);
    end
    pulse();
    chk_all("frzstep", 2'd2, 6'b000001, 16'd1);
    tick();
    chk_all("frzhold", 2'd2, 6'b000001, 16'd1);

    // RUN back on: first adv exactly DIV cycles later
    RUN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rerun", 2'd2, 6'b000001, 16'd1);
    end
    tick();
    chk_all("rerun_adv", 2'd3, 6'b000001, 16'd1);
    RUN = 1'b0;

    // Reset in Q1 of step 3 with a coincident STEPQ
    do_reset();
    for (int i = 0; i < 10; i++) pulse();
    chk_all("pre_rst", 2'd1, 6'b000100, 16'd0);
    RST = 1'b1; STEPQ = 1'b1;
    tick();
    RST = 1'b0; STEPQ = 1'b0;
    chk_all("mid_rst", 2'd3, 6'd0, 16'd0);

    // CYC wrap 0xFFFF -> 0x0000
    for (int i = 0; i < 24; i++) pulse();
    chk_all("pre_wrap", 2'd3, 6'b100000, 16'd0);
    force dut.cyc_q = 16'hFFFF;
    tick();
    release dut.cyc_q;
    tick();
    chk_all("forced", 2'd3, 6'b100000, 16'hFFFF);
    pulse();
    chk_all("wrap", 2'd0, 6'b000001, 16'h0000);

    // DIV=1: quarter rotates every clock
    RUN1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("div1_%0d.qtr", k), 32'(QTR1), 32'((3 + k) % 4));
      chk($sformatf("div1_%0d.stb", k), 32'({CLKO1, CLKE1, CLKS1}), 32'(stb_of(2'((3 + k) % 4))));
    end
    chk("div1.step", 32'(STEP1), 32'(6'b000010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
